ivector_request_mux: RTL and testbench

Transmitter-side front end for the vector request protocol. It collects per-channel `say` traffic from NCHAN independent producers, buffers each channel in a 2-entry FIFO, and issues the traffic as a single method-indexed `say` stream: `say_meth` carries the channel index and `say_v` the payload. Arbitration is round-robin. The block sits upstream of the vector server, which routes each `say` by `meth` into its per-channel FIFOs.

---
 rtl/ivector_request_mux.sv | 166 ++++++++++++++++
 tb/tb_ivector_request_mux.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ivector_request_mux.sv
// Round-robin front end: NCHAN 2-entry channel FIFOs merged into one method-indexed say stream.
// Optional per-channel issue counters (say_count) are built when IVECTOR_MUX_STATS_EN is defined.
module ivector_request_mux #(
  parameter int NCHAN = 10,
  parameter int DW    = 32,
  parameter int MW    = 4
) (
  input  logic                CLK,
  input  logic                nRST,
  input  logic [NCHAN-1:0]    chan_enq_ena,
  input  logic [NCHAN*DW-1:0] chan_enq_v,
  output logic [NCHAN-1:0]    chan_enq_rdy,
  output logic                say_ena,
  output logic [MW-1:0]       say_meth,
  output logic [DW-1:0]       say_v,
  input  logic                say_rdy
`ifdef IVECTOR_MUX_STATS_EN
  ,
  output logic [NCHAN*16-1:0] say_count
`endif
);

  logic [DW-1:0]    head_r    [NCHAN];
  logic [DW-1:0]    tail_r    [NCHAN];
  logic [1:0]       cnt_r     [NCHAN];
  logic [1:0]       cnt_nxt_s [NCHAN];
  logic [MW-1:0]    ptr_r;
  logic [MW-1:0]    ptr_nxt_s;
  logic [NCHAN-1:0] rdy_r;
  logic [NCHAN-1:0] cand_s;
  logic [NCHAN-1:0] enq_s;
  logic [NCHAN-1:0] pop_s;
  logic             any_s;
  logic [MW-1:0]    win_s;
  logic [MW:0]      sum_s;
  logic [MW-1:0]    idx_s;

  // Candidate and accepted-enqueue vectors; a write into a full FIFO is dropped
  always_comb begin
    cand_s = '0;
    enq_s  = '0;
    for (int k = 0; k < NCHAN; k++) begin
      cand_s[k] = (cnt_r[k] != 2'd0);
      enq_s[k]  = chan_enq_ena[k] && (cnt_r[k] != 2'd2);
    end
  end

  // Round-robin scan from ptr; walking offsets high-to-low lets the nearest candidate win
  always_comb begin
    win_s = '0;
    any_s = 1'b0;
    sum_s = '0;
    idx_s = '0;
    for (int i = NCHAN - 1; i >= 0; i--) begin
      sum_s = {1'b0, ptr_r} + (MW+1)'(i);
      if (sum_s >= (MW+1)'(NCHAN)) begin
        sum_s = sum_s - (MW+1)'(NCHAN);
      end else begin
        sum_s = sum_s;
      end
      idx_s = sum_s[MW-1:0];
      if (cand_s[idx_s]) begin
        win_s = idx_s;
        any_s = 1'b1;
      end else begin
        win_s = win_s;
      end
    end
  end

  // Issue outputs straight from FIFO state; say_rdy only gates the strobe
  always_comb begin
    say_ena  = any_s && say_rdy;
    say_meth = '0;
    say_v    = '0;
    if (any_s) begin
      say_meth = win_s;
      say_v    = head_r[win_s];
    end else begin
      say_meth = '0;
      say_v    = '0;
    end
  end

  // Per-channel pop strobes, next counts and the wrapped pointer advance
  always_comb begin
    pop_s     = '0;
    ptr_nxt_s = (win_s == MW'(NCHAN - 1)) ? '0 : win_s + MW'(1);
    for (int k = 0; k < NCHAN; k++) begin
      pop_s[k] = say_ena && (win_s == MW'(k));
      case ({enq_s[k], pop_s[k]})
        2'b10:   cnt_nxt_s[k] = cnt_r[k] + 2'd1;
        2'b01:   cnt_nxt_s[k] = cnt_r[k] - 2'd1;
        default: cnt_nxt_s[k] = cnt_r[k];
      endcase
    end
  end

  // FIFO storage, counts, registered ready and arbitration pointer
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      for (int k = 0; k < NCHAN; k++) begin
        head_r[k] <= '0;
        tail_r[k] <= '0;
        cnt_r[k]  <= 2'd0;
      end
      rdy_r <= '1;
      ptr_r <= '0;
    end else begin
      for (int k = 0; k < NCHAN; k++) begin
        cnt_r[k] <= cnt_nxt_s[k];
        rdy_r[k] <= (cnt_nxt_s[k] != 2'd2);
        case ({enq_s[k], pop_s[k]})
          2'b10: begin
            if (cnt_r[k] == 2'd0) begin
              head_r[k] <= chan_enq_v[k*DW +: DW];
            end else begin
              tail_r[k] <= chan_enq_v[k*DW +: DW];
            end
          end
          2'b01:   head_r[k] <= tail_r[k];
          // Enqueue+pop only happens at cnt=1, so the new word replaces the head
          2'b11:   head_r[k] <= chan_enq_v[k*DW +: DW];
          default: head_r[k] <= head_r[k];
        endcase
      end
      if (say_ena) begin
        ptr_r <= ptr_nxt_s;
      end else begin
        ptr_r <= ptr_r;
      end
    end
  end

  assign chan_enq_rdy = rdy_r;

`ifdef IVECTOR_MUX_STATS_EN
  logic [15:0] stat_r [NCHAN];

  // Free-running 16-bit issue counters, wrapping naturally
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      for (int k = 0; k < NCHAN; k++) begin
        stat_r[k] <= 16'd0;
      end
    end else begin
      for (int k = 0; k < NCHAN; k++) begin
        if (pop_s[k]) begin
          stat_r[k] <= stat_r[k] + 16'd1;
        end else begin
          stat_r[k] <= stat_r[k];
        end
      end
    end
  end

  // Flatten counters onto the output bus
  always_comb begin
    say_count = '0;
    for (int k = 0; k < NCHAN; k++) begin
      say_count[k*16 +: 16] = stat_r[k];
    end
  end
`endif

endmodule

// File: tb/tb_ivector_request_mux.sv
// Self-checking bench for ivector_request_mux: directed scenarios plus randomized traffic
// compared against a queue-based round-robin reference model.
module tb_ivector_request_mux;
  localparam int NCHAN = 10;
  localparam int DW    = 32;
  localparam int MW    = 4;

  logic                CLK = 1'b0;
  logic                nRST;
  logic [NCHAN-1:0]    chan_enq_ena;
  logic [NCHAN*DW-1:0] chan_enq_v;
  logic [NCHAN-1:0]    chan_enq_rdy;
  logic                say_ena;
  logic [MW-1:0]       say_meth;
  logic [DW-1:0]       say_v;
  logic                say_rdy;
`ifdef IVECTOR_MUX_STATS_EN
  logic [NCHAN*16-1:0] say_count;
`endif

  always #5 CLK = ~CLK;

  ivector_request_mux #(.NCHAN(NCHAN), .DW(DW), .MW(MW)) dut (
    .CLK(CLK), .nRST(nRST),
    .chan_enq_ena(chan_enq_ena), .chan_enq_v(chan_enq_v), .chan_enq_rdy(chan_enq_rdy),
    .say_ena(say_ena), .say_meth(say_meth), .say_v(say_v), .say_rdy(say_rdy)
`ifdef IVECTOR_MUX_STATS_EN
    , .say_count(say_count)
`endif
  );

  // Reference model: one queue per channel and an integer round-robin pointer
  logic [DW-1:0] mq [NCHAN][$];
  int mptr;
  int exp_win;
  logic exp_ena;
  logic [MW-1:0] exp_meth;
  logic [DW-1:0] exp_v;
  logic [NCHAN-1:0] exp_rdy;
  int checks = 0;
  int errors = 0;

  function automatic logic [NCHAN*DW-1:0] put(input int k, input logic [DW-1:0] val);
    logic [NCHAN*DW-1:0] r;
    r = '0;
    r[k*DW +: DW] = val;
    return r;
  endfunction

  function automatic logic [NCHAN-1:0] bit_of(input int k);
    logic [NCHAN-1:0] r;
    r = '0;
    r[k] = 1'b1;
    return r;
  endfunction

  task automatic predict();
    exp_win = -1;
    for (int i = 0; i < NCHAN; i++) begin
      int c;
      c = (mptr + i) % NCHAN;
      if (exp_win < 0 && mq[c].size() > 0) exp_win = c;
    end
    exp_ena  = (exp_win >= 0) && say_rdy;
    exp_meth = (exp_win >= 0) ? MW'(exp_win) : '0;
    exp_v    = (exp_win >= 0) ? mq[exp_win][0] : '0;
    for (int k = 0; k < NCHAN; k++) exp_rdy[k] = (mq[k].size() != 2);
  endtask

  task automatic drive(input logic [NCHAN-1:0] enq, input logic [NCHAN*DW-1:0] d, input logic rdy);
    chan_enq_ena = enq;
    chan_enq_v   = d;
    say_rdy      = rdy;
    #1;
    predict();
  endtask

  task automatic tick();
    bit full [NCHAN];
    for (int k = 0; k < NCHAN; k++) full[k] = (mq[k].size() == 2);
    if (!nRST) begin
      for (int k = 0; k < NCHAN; k++) mq[k].delete();
      mptr = 0;
    end else begin
      if (exp_ena) begin
        void'(mq[exp_win].pop_front());
        mptr = (exp_win + 1) % NCHAN;
      end
      for (int k = 0; k < NCHAN; k++)
        if (chan_enq_ena[k] && !full[k]) mq[k].push_back(chan_enq_v[k*DW +: DW]);
    end
    @(posedge CLK);
    @(negedge CLK);
  endtask

  task automatic do_reset();
    nRST = 1'b0;
    drive('0, '0, 1'b1);
    tick();
    tick();
    nRST = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    drive('0, '0, 1'b1);
    checks++; if (chan_enq_rdy !== 10'h3FF) begin errors++; $display("FAIL reset_rdy got %h want 3ff", chan_enq_rdy); end
    checks++; if (say_ena !== 1'b0) begin errors++; $display("FAIL reset_ena got %b want 0", say_ena); end
    checks++; if (say_meth !== 4'd0) begin errors++; $display("FAIL reset_meth got %0d want 0", say_meth); end
    checks++; if (say_v !== 32'd0) begin errors++; $display("FAIL reset_v got %h want 0", say_v); end
    tick();
  endtask

  task automatic test_single();
    drive(bit_of(3), put(3, 32'hDEADBEEF), 1'b1);
    checks++; if (say_ena !== 1'b0) begin errors++; $display("FAIL single_c0_ena got %b want 0", say_ena); end
    tick();
    drive('0, '0, 1'b1);
    checks++; if (say_ena !== 1'b1) begin errors++; $display("FAIL single_c1_ena got %b want 1", say_ena); end
    checks++; if (say_meth !== 4'd3) begin errors++; $display("FAIL single_c1_meth got %0d want 3", say_meth); end
    checks++; if (say_v !== 32'hDEADBEEF) begin errors++; $display("FAIL single_c1_v got %h want deadbeef", say_v); end
    tick();
    // ptr is now 4: channels 2 and 5 arrive together, 5 must win first
    drive(bit_of(2) | bit_of(5), put(2, 32'h22) | put(5, 32'h55), 1'b1);
    checks++; if (say_ena !== 1'b0) begin errors++; $display("FAIL single_c2_ena got %b want 0", say_ena); end
    tick();
    drive('0, '0, 1'b1);
    checks++; if (say_meth !== 4'd5 || say_v !== 32'h55) begin errors++; $display("FAIL ptr_after_3 got meth %0d v %h want 5 55", say_meth, say_v); end
    tick();
    drive('0, '0, 1'b1);
    checks++; if (say_meth !== 4'd2 || say_v !== 32'h22) begin errors++; $display("FAIL ptr_wrap got meth %0d v %h want 2 22", say_meth, say_v); end
    tick();
  endtask

  task automatic test_round_robin();
    int order [6] = '{0, 5, 9, 0, 5, 9};
    int xfers = 0;
    logic [NCHAN-1:0] m;
    logic [NCHAN*DW-1:0] d;
    do_reset();
    m = bit_of(0) | bit_of(5) | bit_of(9);
    for (int r = 0; r < 2; r++) begin
      d = '0;
      for (int k = 0; k < NCHAN; k++) d[k*DW +: DW] = (r == 0 ? 32'hA000_0000 : 32'hB000_0000) | 32'(k);
      drive(m, d, 1'b0);
      tick();
    end
    drive('0, '0, 1'b0);
    checks++; if (chan_enq_rdy !== 10'h1DE) begin errors++; $display("FAIL rr_full_rdy got %h want 1de", chan_enq_rdy); end
    for (int i = 0; i < 8; i++) begin
      drive('0, '0, 1'b1);
      if (say_ena === 1'b1) xfers++;
      if (i < 6) begin
        checks++;
        if (say_ena !== 1'b1 || say_meth !== MW'(order[i]) ||
            say_v !== ((i < 3 ? 32'hA000_0000 : 32'hB000_0000) | 32'(order[i]))) begin
          errors++; $display("FAIL rr_issue_%0d got ena %b meth %0d v %h want 1 %0d", i, say_ena, say_meth, say_v, order[i]);
        end
      end else begin
        checks++; if (say_ena !== 1'b0) begin errors++; $display("FAIL rr_drain_%0d got ena %b want 0", i, say_ena); end
      end
      tick();
    end
    checks++; if (xfers != 6) begin errors++; $display("FAIL rr_count got %0d want 6", xfers); end
  endtask

  task automatic test_backpressure();
    drive(bit_of(7), put(7, 32'h7000_0001), 1'b0);
    tick();
    drive(bit_of(7), put(7, 32'h7000_0002), 1'b0);
    checks++; if (chan_enq_rdy[7] !== 1'b1 || say_ena !== 1'b0) begin errors++; $display("FAIL bp_one got rdy %b ena %b want 1 0", chan_enq_rdy[7], say_ena); end
    tick();
    drive('0, '0, 1'b0);
    checks++; if (chan_enq_rdy[7] !== 1'b0 || say_ena !== 1'b0) begin errors++; $display("FAIL bp_full got rdy %b ena %b want 0 0", chan_enq_rdy[7], say_ena); end
    tick();
    drive('0, '0, 1'b1);
    checks++; if (say_ena !== 1'b1 || say_meth !== 4'd7 || say_v !== 32'h7000_0001 || chan_enq_rdy[7] !== 1'b0) begin
      errors++; $display("FAIL bp_pop1 got ena %b meth %0d v %h rdy %b want 1 7 70000001 0", say_ena, say_meth, say_v, chan_enq_rdy[7]); end
    tick();
    drive('0, '0, 1'b1);
    checks++; if (say_ena !== 1'b1 || say_v !== 32'h7000_0002 || chan_enq_rdy[7] !== 1'b1) begin
      errors++; $display("FAIL bp_pop2 got ena %b v %h rdy %b want 1 70000002 1", say_ena, say_v, chan_enq_rdy[7]); end
    tick();
    drive('0, '0, 1'b1);
    checks++; if (say_ena !== 1'b0) begin errors++; $display("FAIL bp_empty got ena %b want 0", say_ena); end
    tick();
  endtask

  task automatic test_enq_pop();
    drive(bit_of(2), put(2, 32'h5A), 1'b0);
    tick();
    drive(bit_of(2), put(2, 32'h11), 1'b1);
    checks++; if (say_ena !== 1'b1 || say_meth !== 4'd2 || say_v !== 32'h5A) begin
      errors++; $display("FAIL ep_head got ena %b meth %0d v %h want 1 2 5a", say_ena, say_meth, say_v); end
    tick();
    drive('0, '0, 1'b0);
    checks++; if (say_v !== 32'h11 || say_meth !== 4'd2 || chan_enq_rdy[2] !== 1'b1) begin
      errors++; $display("FAIL ep_new_head got v %h meth %0d rdy %b want 11 2 1", say_v, say_meth, chan_enq_rdy[2]); end
    tick();
    drive('0, '0, 1'b1);
    tick();
    drive('0, '0, 1'b1);
    checks++; if (say_ena !== 1'b0) begin errors++; $display("FAIL ep_cnt1 got ena %b want 0", say_ena); end
    tick();
  endtask

  task automatic test_overflow();
    drive(bit_of(4), put(4, 32'h41), 1'b0); tick();
    drive(bit_of(4), put(4, 32'h42), 1'b0); tick();
    drive(bit_of(4), put(4, 32'hBAD), 1'b0); tick();
    drive('0, '0, 1'b1);
    checks++; if (say_v !== 32'h41) begin errors++; $display("FAIL ovf_first got %h want 41", say_v); end
    tick();
    drive('0, '0, 1'b1);
    checks++; if (say_v !== 32'h42) begin errors++; $display("FAIL ovf_second got %h want 42", say_v); end
    tick();
    drive('0, '0, 1'b1);
    checks++; if (say_ena !== 1'b0) begin errors++; $display("FAIL ovf_dropped got ena %b want 0", say_ena); end
    tick();
  endtask

  task automatic test_backlog();
    logic [NCHAN-1:0] m;
    logic [NCHAN*DW-1:0] d;
    int first = -1;
    int n = 0;
    for (int cyc = 0; cyc < 4 * NCHAN; cyc++) begin
      for (int k = 0; k < NCHAN; k++) begin
        m[k] = (mq[k].size() < 2);
        d[k*DW +: DW] = $urandom;
      end
      drive(m, d, 1'b1);
      if (cyc >= 1) begin
        if (first < 0) first = exp_win;
        checks++;
        if (say_ena !== 1'b1 || say_meth !== MW'((first + n) % NCHAN) || say_v !== exp_v) begin
          errors++; $display("FAIL backlog_%0d got ena %b meth %0d want 1 %0d", cyc, say_ena, say_meth, (first + n) % NCHAN);
        end
        n++;
      end
      tick();
    end
    do_reset();
  endtask

  task automatic test_random();
    logic [NCHAN-1:0] m;
    logic [NCHAN*DW-1:0] d;
    for (int cyc = 0; cyc < 2000; cyc++) begin
      for (int k = 0; k < NCHAN; k++) begin
        m[k] = ($urandom_range(2) == 0);
        d[k*DW +: DW] = $urandom;
      end
      nRST = ($urandom_range(299) != 0);
      drive(m, d, $urandom_range(3) != 0);
      checks++;
      if (say_ena !== exp_ena || say_meth !== exp_meth || say_v !== exp_v || chan_enq_rdy !== exp_rdy) begin
        errors++; $display("FAIL random_%0d got ena %b meth %0d v %h rdy %h want %b %0d %h %h",
                           cyc, say_ena, say_meth, say_v, chan_enq_rdy, exp_ena, exp_meth, exp_v, exp_rdy);
      end
      tick();
    end
    nRST = 1'b1;
    do_reset();
  endtask

`ifdef IVECTOR_MUX_STATS_EN
  task automatic test_stats();
    do_reset();
    for (int n = 0; n < 65538; n++) begin
      drive(bit_of(1), put(1, 32'(n)), 1'b1);
      tick();
    end
    drive('0, '0, 1'b0);
    for (int k = 0; k < NCHAN; k++) begin
      checks++;
      if (say_count[k*16 +: 16] !== (k == 1 ? 16'd1 : 16'd0)) begin
        errors++; $display("FAIL stats_cnt_%0d got %0d want %0d", k, say_count[k*16 +: 16], (k == 1) ? 1 : 0);
      end
    end
    for (int n = 0; n < 5; n++) begin
      drive(bit_of(1) | bit_of(6), put(1, 32'h1) | put(6, 32'h6), 1'b1);
      tick();
    end
    nRST = 1'b0;
    drive(bit_of(1), put(1, 32'h99), 1'b1);
    tick();
    nRST = 1'b1;
    drive('0, '0, 1'b1);
    checks++; if (say_count !== '0) begin errors++; $display("FAIL stats_reset_cnt got %h want 0", say_count); end
    checks++; if (chan_enq_rdy !== 10'h3FF || say_ena !== 1'b0) begin
      errors++; $display("FAIL stats_reset_fifo got rdy %h ena %b want 3ff 0", chan_enq_rdy, say_ena); end
    tick();
  endtask
`endif

  initial begin
    nRST = 1'b0;
    chan_enq_ena = '0;
    chan_enq_v = '0;
    say_rdy = 1'b1;
    mptr = 0;
    @(negedge CLK);
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_enq_pop();
    test_overflow();
    test_backlog();
    test_random();
`ifdef IVECTOR_MUX_STATS_EN
    test_stats();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
